// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter
// Converts one 256-bit L2 line transfer into a 4-beat x 64-bit burst on the
// physical-memory bus. Services line fills (reads) and dirty write-backs
// (writes), one request at a time. All outputs are registered.
module l2_cacheline_adapter #(
  parameter int S_OFFSET  = 5,
  parameter int S_LINE    = 256,
  parameter int S_BEAT    = 64,
  parameter int NUM_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  // L2 side
  input  logic [31:0]       l2_address_i,
  input  logic              l2_read_i,
  input  logic              l2_write_i,
  input  logic [S_LINE-1:0] l2_wdata256_i,
  output logic [S_LINE-1:0] l2_rdata256_o,
  output logic              l2_resp_o,
  // physical-memory side
  output logic [31:0]       mem_address_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [S_BEAT-1:0] mem_wdata64_o,
  input  logic [S_BEAT-1:0] mem_rdata64_i,
  input  logic              mem_resp_i
);

  localparam int CW = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [S_LINE-1:0] wline_q,     wline_d;
  logic [S_LINE-1:0] rline_q,     rline_d;
  logic [31:0]       addr_q,      addr_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [S_BEAT-1:0] wdata_q,     wdata_d;
  logic              resp_q,      resp_d;

  logic              last_beat_s;

  // Offset bits inside the line never reach the memory bus.
  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^l2_address_i[S_OFFSET-1:0];

  assign last_beat_s = (cnt_q == CW'(NUM_BEATS - 1));

  // Next-state and next-output logic for the burst FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wline_d     = wline_q;
    rline_d     = rline_q;
    addr_d      = addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    wdata_d     = wdata_q;
    resp_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (l2_write_i) begin
          // write wins when both requests are raised together
          state_d     = WR_BURST;
          addr_d      = {l2_address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
          wline_d     = l2_wdata256_i;
          wdata_d     = l2_wdata256_i[S_BEAT-1:0];
          mem_write_d = 1'b1;
          mem_read_d  = 1'b0;
        end else if (l2_read_i) begin
          state_d     = RD_BURST;
          addr_d      = {l2_address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end

      RD_BURST: begin
        if (mem_resp_i) begin
          // beats fill the line in ascending order; old line bits stay
          // visible until each slice is overwritten
          rline_d[cnt_q*S_BEAT +: S_BEAT] = mem_rdata64_i;
          cnt_d = cnt_q + CW'(1);
          if (last_beat_s) begin
            state_d    = DONE;
            mem_read_d = 1'b0;
            resp_d     = 1'b1;
          end else begin
            mem_read_d = 1'b1;
          end
        end else begin
          mem_read_d = 1'b1;
        end
      end

      WR_BURST: begin
        if (mem_resp_i) begin
          cnt_d   = cnt_q + CW'(1);
          wdata_d = wline_q[cnt_d*S_BEAT +: S_BEAT];
          if (last_beat_s) begin
            state_d     = DONE;
            mem_write_d = 1'b0;
            resp_d      = 1'b1;
          end else begin
            mem_write_d = 1'b1;
          end
        end else begin
          mem_write_d = 1'b1;
        end
      end

      DONE: begin
        // the completion pulse is already on the bus; requests ignored here
        state_d     = IDLE;
        cnt_d       = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any burst without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      addr_q      <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wdata_q     <= '0;
      resp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
    end
  end

  assign l2_rdata256_o = rline_q;
  assign l2_resp_o     = resp_q;
  assign mem_address_o = addr_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_wdata64_o = wdata_q;

endmodule
